// File: rtl/fp_mul_if.sv
// Issue/result port between the scheduler and the FMUL.S functional unit.
// The scheduler is the master: it drives the issue fields and receives wakeup/result.
interface fp_mul_if #(
  parameter int SPEC_STATES = 4,
  parameter int ROB_W       = 6,
  parameter int PRF_W       = 7
);
  logic                   Port_Valid;
  logic [31:0]            in_op1;
  logic [31:0]            in_op2;
  logic [2:0]             in_rm;
  logic [ROB_W-1:0]       in_rob;
  logic [PRF_W-1:0]       in_rd;
  logic [SPEC_STATES-1:0] in_spectag;

  logic                   Ready;
  logic                   wake_valid;
  logic [PRF_W-1:0]       wake_rd;
  logic                   res_valid;
  logic [ROB_W-1:0]       res_rob;
  logic [PRF_W-1:0]       res_rd;
  logic [31:0]            res_value;
  logic [4:0]             res_fflags;
  logic                   res_exc;

  modport master (
    output Port_Valid, in_op1, in_op2, in_rm, in_rob, in_rd, in_spectag,
    input  Ready, wake_valid, wake_rd, res_valid, res_rob, res_rd,
           res_value, res_fflags, res_exc
  );

  modport slave (
    input  Port_Valid, in_op1, in_op2, in_rm, in_rob, in_rd, in_spectag,
    output Ready, wake_valid, wake_rd, res_valid, res_rob, res_rd,
           res_value, res_fflags, res_exc
  );
endinterface

// File: rtl/fp_mul_fu.sv
// Three-stage binary32 multiplier (flush-to-zero) with early wakeup, flush and
// speculative kill. S1: decode + significand product, S2: normalise + round, S3: pack.
module fp_mul_fu #(
  parameter int SPEC_STATES = 4,
  parameter int ROB_W       = 6,
  parameter int PRF_W       = 7
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   Flush,
  input  logic                   Kill_Enable,
  input  logic [SPEC_STATES-1:0] Kill_VKillMask,
  input  logic [2:0]             fcsr_frm,
  fp_mul_if.slave                port
);
  localparam logic [2:0] RM_RNE = 3'd0;
  localparam logic [2:0] RM_RTZ = 3'd1;
  localparam logic [2:0] RM_RDN = 3'd2;
  localparam logic [2:0] RM_RUP = 3'd3;
  localparam logic [2:0] RM_RMM = 3'd4;
  localparam logic [2:0] RM_DYN = 3'd7;
  localparam logic [31:0] QNAN  = 32'h7FC0_0000;

  typedef struct packed {
    logic                   valid;
    logic [ROB_W-1:0]       rob;
    logic [PRF_W-1:0]       rd;
    logic [SPEC_STATES-1:0] spectag;
  } tag_t;

  typedef struct packed {
    logic        exc;
    logic        special;
    logic [31:0] spec_value;
    logic [4:0]  spec_flags;
    logic        sign;
    logic [2:0]  rm;
  } ctl_t;

  // An op survives the current edge unless flushed or hit by a matching kill.
  // Outputs are gated the same way so a dying op never shows wakeup or result.
  function automatic logic survives(input tag_t t, input logic flush, input logic kill_en,
                                    input logic [SPEC_STATES-1:0] mask);
    return t.valid && !flush && !(kill_en && ((t.spectag & mask) != '0));
  endfunction

  function automatic tag_t next_tag(input tag_t t, input logic flush, input logic kill_en,
                                    input logic [SPEC_STATES-1:0] mask);
    tag_t n;
    n       = t;
    n.valid = survives(t, flush, kill_en, mask);
    return n;
  endfunction

  tag_t              in_tag, s1_tag, s2_tag, s3_tag;
  ctl_t              in_ctl, s1_ctl, s2_ctl;
  logic signed [9:0] in_exp, s1_exp, exp_n, rnd_exp, s2_exp;
  logic [47:0]       in_prod, s1_prod;
  logic [22:0]       mant, rnd_mant, s2_mant;
  logic              norm, rbit, sticky, round_up, rnd_inexact, s2_inexact;
  logic [24:0]       rnd_sum;
  logic [31:0]       out_value, s3_value;
  logic [4:0]        out_flags, s3_flags;
  logic              s3_exc;

  logic [7:0]  e1, e2;
  logic [22:0] f1, f2;
  logic        zero1, zero2, inf1, inf2, nan1, nan2, snan1, snan2;
  logic [2:0]  eff_rm;

  assign in_tag = {port.Port_Valid, port.in_rob, port.in_rd, port.in_spectag};
  assign e1     = port.in_op1[30:23];
  assign e2     = port.in_op2[30:23];
  assign f1     = port.in_op1[22:0];
  assign f2     = port.in_op2[22:0];
  assign zero1  = (e1 == 8'h00);
  assign zero2  = (e2 == 8'h00);
  assign inf1   = (e1 == 8'hFF) && (f1 == '0);
  assign inf2   = (e2 == 8'hFF) && (f2 == '0);
  assign nan1   = (e1 == 8'hFF) && (f1 != '0);
  assign nan2   = (e2 == 8'hFF) && (f2 != '0);
  assign snan1  = nan1 && !f1[22];
  assign snan2  = nan2 && !f2[22];
  assign eff_rm = (port.in_rm == RM_DYN) ? fcsr_frm : port.in_rm;
  assign in_exp = $signed({2'b00, e1}) + $signed({2'b00, e2}) - 10'sd127;
  assign in_prod = {1'b1, f1} * {1'b1, f2};

  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    in_ctl      = '0;
    in_ctl.exc  = (eff_rm > RM_RMM);
    in_ctl.sign = port.in_op1[31] ^ port.in_op2[31];
    in_ctl.rm   = eff_rm;
    if (nan1 || nan2) begin
      in_ctl.special    = 1'b1;
      in_ctl.spec_value = QNAN;
      in_ctl.spec_flags = {snan1 || snan2, 4'b0000};
    end else if ((inf1 && zero2) || (inf2 && zero1)) begin
      in_ctl.special    = 1'b1;
      in_ctl.spec_value = QNAN;
      in_ctl.spec_flags = 5'b10000;
    end else if (inf1 || inf2) begin
      in_ctl.special    = 1'b1;
      in_ctl.spec_value = {in_ctl.sign, 8'hFF, 23'd0};
    end else if (zero1 || zero2) begin
      in_ctl.special    = 1'b1;
      in_ctl.spec_value = {in_ctl.sign, 31'd0};
    end
  end

  // Normalise by 0/1 bit, round on round bit + sticky, fold a mantissa carry into the exponent.
  always_comb begin
    norm    = s1_prod[47];
    mant    = norm ? s1_prod[46:24] : s1_prod[45:23];
    rbit    = norm ? s1_prod[23]    : s1_prod[22];
    sticky  = norm ? (|s1_prod[22:0]) : (|s1_prod[21:0]);
    exp_n   = s1_exp + (norm ? 10'sd1 : 10'sd0);
    case (s1_ctl.rm)
      RM_RNE:  round_up = rbit && (sticky || mant[0]);
      RM_RDN:  round_up = s1_ctl.sign && (rbit || sticky);
      RM_RUP:  round_up = !s1_ctl.sign && (rbit || sticky);
      RM_RMM:  round_up = rbit;
      default: round_up = 1'b0;
    endcase
    rnd_sum     = {1'b0, 1'b1, mant} + {24'd0, round_up};
    rnd_exp     = rnd_sum[24] ? exp_n + 10'sd1 : exp_n;
    rnd_mant    = rnd_sum[24] ? rnd_sum[23:1] : rnd_sum[22:0];
    rnd_inexact = rbit || sticky;
  end

  always_comb begin
    out_value = '0;
    out_flags = '0;
    if (s2_ctl.exc) begin
      out_value = '0;
    end else if (s2_ctl.special) begin
      out_value = s2_ctl.spec_value;
      out_flags = s2_ctl.spec_flags;
    end else if (s2_exp >= 10'sd255) begin
      out_flags = 5'b00101;
      case (s2_ctl.rm)
        RM_RTZ:  out_value = {s2_ctl.sign, 8'hFE, 23'h7FFFFF};
        RM_RDN:  out_value = s2_ctl.sign ? {1'b1, 8'hFF, 23'd0} : {1'b0, 8'hFE, 23'h7FFFFF};
        RM_RUP:  out_value = s2_ctl.sign ? {1'b1, 8'hFE, 23'h7FFFFF} : {1'b0, 8'hFF, 23'd0};
        default: out_value = {s2_ctl.sign, 8'hFF, 23'd0};
      endcase
    end else if (s2_exp < 10'sd1) begin
      out_value = {s2_ctl.sign, 31'd0};
      out_flags = 5'b00011;
    end else begin
      out_value = {s2_ctl.sign, s2_exp[7:0], s2_mant};
      out_flags = {4'b0000, s2_inexact};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_tag <= '0;
      s2_tag <= '0;
      s3_tag <= '0;
    end else begin
      s1_tag <= next_tag(in_tag, Flush, Kill_Enable, Kill_VKillMask);
      s2_tag <= next_tag(s1_tag, Flush, Kill_Enable, Kill_VKillMask);
      s3_tag <= next_tag(s2_tag, Flush, Kill_Enable, Kill_VKillMask);
    end
  end

  // NOTE: datapath registers carry no reset; the stage valids alone qualify them.
  always_ff @(posedge clk) begin
    s1_ctl     <= in_ctl;
    s1_exp     <= in_exp;
    s1_prod    <= in_prod;
    s2_ctl     <= s1_ctl;
    s2_exp     <= rnd_exp;
    s2_mant    <= rnd_mant;
    s2_inexact <= rnd_inexact;
    s3_value   <= out_value;
    s3_flags   <= out_flags;
    s3_exc     <= s2_ctl.exc;
  end

  logic wake_live, res_live;
  assign wake_live = survives(s2_tag, Flush, Kill_Enable, Kill_VKillMask);
  assign res_live  = survives(s3_tag, Flush, Kill_Enable, Kill_VKillMask);

  always_comb begin
    port.Ready      = 1'b1;
    port.wake_valid = wake_live;
    port.wake_rd    = wake_live ? s2_tag.rd : '0;
    port.res_valid  = res_live;
    port.res_rob    = res_live ? s3_tag.rob : '0;
    port.res_rd     = res_live ? s3_tag.rd  : '0;
    port.res_value  = res_live ? s3_value   : '0;
    port.res_fflags = res_live ? s3_flags   : '0;
    port.res_exc    = res_live && s3_exc;
  end
endmodule

// File: tb/tb_fp_mul_fu.sv
// Bench for fp_mul_fu: directed corner cases, kill/flush/reset scenarios and a
// randomized stream scored against an integer-arithmetic binary32 multiply model.
module tb_fp_mul_fu;
  localparam int SPEC_STATES = 4;
  localparam int ROB_W       = 6;
  localparam int PRF_W       = 7;
  localparam int SB_DEPTH    = 1024;

  typedef struct packed {
    logic        exc;
    logic [4:0]  flags;
    logic [31:0] value;
  } res_t;

  typedef struct packed {
    logic                   valid;
    logic [ROB_W-1:0]       rob;
    logic [PRF_W-1:0]       rd;
    logic [SPEC_STATES-1:0] spectag;
    res_t                   res;
  } exp_t;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   Flush;
  logic                   Kill_Enable;
  logic [SPEC_STATES-1:0] Kill_VKillMask;
  logic [2:0]             fcsr_frm;

  fp_mul_if #(.SPEC_STATES(SPEC_STATES), .ROB_W(ROB_W), .PRF_W(PRF_W)) bus ();

  fp_mul_fu #(.SPEC_STATES(SPEC_STATES), .ROB_W(ROB_W), .PRF_W(PRF_W)) dut (
    .clk            (clk),
    .rst            (rst),
    .Flush          (Flush),
    .Kill_Enable    (Kill_Enable),
    .Kill_VKillMask (Kill_VKillMask),
    .fcsr_frm       (fcsr_frm),
    .port           (bus.slave)
  );

  always #5 clk = ~clk;

  // sb[n] holds the result expected in step n; the wakeup for step n is sb[n+1].
  exp_t sb [SB_DEPTH];
  int   step  = 0;
  int   tests = 0;
  int   fails = 0;

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    tests++;
    assert (observed === expected) else begin
      fails++;
      $error("FAIL %s step %0d: observed %h expected %h", tag, step, observed, expected);
    end
  endtask

  // Reference multiply: exact integer significand product, rounding decided by
  // comparing the discarded remainder against one half ulp.
  function automatic res_t ref_mul(input logic [31:0] a, input logic [31:0] b, input logic [2:0] rm);
    res_t            r;
    logic            sign, a_nan, b_nan, a_snan, b_snan, a_inf, b_inf, a_zero, b_zero, inc, up;
    longint unsigned p, q, rem, half;
    int              e, n;
    r    = '0;
    sign = a[31] ^ b[31];
    if (rm > 3'd4) begin
      r.exc = 1'b1;
      return r;
    end
    a_nan  = (a[30:23] == 8'hFF) && (a[22:0] != 0);
    b_nan  = (b[30:23] == 8'hFF) && (b[22:0] != 0);
    a_snan = a_nan && !a[22];
    b_snan = b_nan && !b[22];
    a_inf  = (a[30:23] == 8'hFF) && (a[22:0] == 0);
    b_inf  = (b[30:23] == 8'hFF) && (b[22:0] == 0);
    a_zero = (a[30:23] == 8'h00);
    b_zero = (b[30:23] == 8'h00);
    if (a_nan || b_nan) begin
      r.value = 32'h7FC00000;
      r.flags = {a_snan || b_snan, 4'b0000};
      return r;
    end
    if ((a_inf && b_zero) || (b_inf && a_zero)) begin
      r.value = 32'h7FC00000;
      r.flags = 5'b10000;
      return r;
    end
    if (a_inf || b_inf) begin
      r.value = {sign, 8'hFF, 23'd0};
      return r;
    end
    if (a_zero || b_zero) begin
      r.value = {sign, 31'd0};
      return r;
    end
    p    = {40'd0, 1'b1, a[22:0]} * {40'd0, 1'b1, b[22:0]};
    n    = (p >= (64'd1 << 47)) ? 24 : 23;
    e    = int'(a[30:23]) + int'(b[30:23]) - 127 + (n - 23);
    q    = p >> n;
    rem  = p - (q << n);
    half = 64'd1 << (n - 1);
    case (rm)
      3'd0:    inc = (rem > half) || ((rem == half) && q[0]);
      3'd2:    inc = sign && (rem != 0);
      3'd3:    inc = !sign && (rem != 0);
      3'd4:    inc = (rem >= half);
      default: inc = 1'b0;
    endcase
    q = q + {63'd0, inc};
    if (q == (64'd1 << 24)) begin
      q = q >> 1;
      e = e + 1;
    end
    if (e >= 255) begin
      up      = (rm == 3'd0) || (rm == 3'd4) || (rm == 3'd2 && sign) || (rm == 3'd3 && !sign);
      r.value = up ? {sign, 8'hFF, 23'd0} : {sign, 8'hFE, 23'h7FFFFF};
      r.flags = 5'b00101;
    end else if (e < 1) begin
      r.value = {sign, 31'd0};
      r.flags = 5'b00011;
    end else begin
      r.value = {sign, e[7:0], q[22:0]};
      r.flags = {4'b0000, rem != 0};
    end
    return r;
  endfunction

  function automatic logic [31:0] rand_fp();
    logic [31:0] sp [7];
    int          sel;
    sp[0] = 32'h00000000; sp[1] = 32'h80000000; sp[2] = 32'h7F800000; sp[3] = 32'hFF800000;
    sp[4] = 32'h7FC00000; sp[5] = 32'h7F800001; sp[6] = 32'h00400000;
    sel = $urandom_range(0, 9);
    if (sel == 0) return sp[$urandom_range(0, 6)];
    if (sel < 3)  return {1'($urandom), 8'($urandom_range(1, 254)), 23'($urandom)};
    return {1'($urandom), 8'($urandom_range(100, 154)), 23'($urandom)};
  endfunction

  task automatic idle_inputs();
    bus.Port_Valid = 1'b0;
    Flush          = 1'b0;
    Kill_Enable    = 1'b0;
    Kill_VKillMask = '0;
  endtask

  task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic [2:0] rm,
                       input logic [2:0] frm, input logic [3:0] tag, input res_t r);
    bus.Port_Valid = 1'b1;
    bus.in_op1     = a;
    bus.in_op2     = b;
    bus.in_rm      = rm;
    bus.in_rob     = 6'($urandom);
    bus.in_rd      = 7'($urandom);
    bus.in_spectag = tag;
    fcsr_frm       = frm;
    sb[step+3].valid   = 1'b1;
    sb[step+3].rob     = bus.in_rob;
    sb[step+3].rd      = bus.in_rd;
    sb[step+3].spectag = tag;
    sb[step+3].res     = r;
  endtask

  task automatic issue_const(input logic [31:0] a, input logic [31:0] b, input logic [2:0] rm,
                             input logic [2:0] frm, input logic [3:0] tag, input logic [31:0] value,
                             input logic [4:0] flags, input logic exc);
    res_t r;
    r.exc   = exc;
    r.flags = flags;
    r.value = value;
    drive(a, b, rm, frm, tag, r);
  endtask

  task automatic issue_rand(input logic [3:0] tag);
    logic [31:0] a, b;
    logic [2:0]  rm, frm;
    a   = rand_fp();
    b   = rand_fp();
    rm  = 3'($urandom_range(0, 7));
    frm = 3'($urandom_range(0, 7));
    drive(a, b, rm, frm, tag, ref_mul(a, b, (rm == 3'd7) ? frm : rm));
  endtask

  // One cycle: retire cancelled expectations, compare outputs, move to the next cycle.
  task automatic advance();
    logic [51:0] exp_res;
    logic [7:0]  exp_wake;
    for (int k = step; k < step + 5; k++) begin
      if (Flush) sb[k].valid = 1'b0;
      else if (Kill_Enable && ((sb[k].spectag & Kill_VKillMask) != 0)) sb[k].valid = 1'b0;
    end
    #1;
    exp_res  = sb[step].valid ? {1'b1, sb[step].rob, sb[step].rd, sb[step].res.value,
                                 sb[step].res.flags, sb[step].res.exc} : 52'd0;
    exp_wake = sb[step+1].valid ? {1'b1, sb[step+1].rd} : 8'd0;
    check("res_valid", 64'(bus.res_valid), 64'(exp_res[51]));
    check("result", 64'({bus.res_valid, bus.res_rob, bus.res_rd, bus.res_value, bus.res_fflags,
                         bus.res_exc}), 64'(exp_res));
    check("wakeup", 64'({bus.wake_valid, bus.wake_rd}), 64'(exp_wake));
    @(negedge clk);
    step++;
    idle_inputs();
  endtask

  initial begin
    for (int k = 0; k < SB_DEPTH; k++) sb[k] = '0;
    rst = 1'b0;
    idle_inputs();
    fcsr_frm       = 3'd0;
    bus.in_op1     = '0;
    bus.in_op2     = '0;
    bus.in_rm      = '0;
    bus.in_rob     = '0;
    bus.in_rd      = '0;
    bus.in_spectag = '0;
    repeat (3) @(negedge clk);
    #1;
    check("reset_res", 64'({bus.res_valid, bus.res_rob, bus.res_rd, bus.res_value,
                            bus.res_fflags, bus.res_exc}), 64'd0);
    check("reset_wake", 64'({bus.wake_valid, bus.wake_rd}), 64'd0);
    check("reset_ready", 64'(bus.Ready), 64'd1);
    @(negedge clk);
    rst = 1'b1;

    // Directed corner cases, issued back to back.
    issue_const(32'h3FC00000, 32'h40000000, 3'd0, 3'd0, 4'b0001, 32'h40400000, 5'h00, 1'b0); advance();
    issue_const(32'h3F800001, 32'h3F800001, 3'd0, 3'd0, 4'b0001, 32'h3F800002, 5'h01, 1'b0); advance();
    issue_const(32'h3F800001, 32'h3F800001, 3'd3, 3'd0, 4'b0001, 32'h3F800003, 5'h01, 1'b0); advance();
    issue_const(32'h3F800001, 32'h3F800001, 3'd7, 3'd1, 4'b0001, 32'h3F800002, 5'h01, 1'b0); advance();
    issue_const(32'h7F800000, 32'h00000000, 3'd0, 3'd0, 4'b0001, 32'h7FC00000, 5'h10, 1'b0); advance();
    issue_const(32'h7F800001, 32'h3F800000, 3'd0, 3'd0, 4'b0001, 32'h7FC00000, 5'h10, 1'b0); advance();
    issue_const(32'hFF800000, 32'h40000000, 3'd0, 3'd0, 4'b0001, 32'hFF800000, 5'h00, 1'b0); advance();
    issue_const(32'h7F000000, 32'h7F000000, 3'd1, 3'd0, 4'b0001, 32'h7F7FFFFF, 5'h05, 1'b0); advance();
    issue_const(32'h7F000000, 32'h7F000000, 3'd0, 3'd0, 4'b0001, 32'h7F800000, 5'h05, 1'b0); advance();
    issue_const(32'hFF000000, 32'h7F000000, 3'd2, 3'd0, 4'b0001, 32'hFF800000, 5'h05, 1'b0); advance();
    issue_const(32'hFF000000, 32'h7F000000, 3'd3, 3'd0, 4'b0001, 32'hFF7FFFFF, 5'h05, 1'b0); advance();
    issue_const(32'h00800000, 32'h3F000000, 3'd0, 3'd0, 4'b0001, 32'h00000000, 5'h03, 1'b0); advance();
    issue_const(32'h3FC00000, 32'h40000000, 3'd5, 3'd0, 4'b0001, 32'h00000000, 5'h00, 1'b1); advance();
    issue_const(32'h3FC00000, 32'h40000000, 3'd7, 3'd6, 4'b0001, 32'h00000000, 5'h00, 1'b1); advance();
    repeat (4) advance();

    // Kill: ops tagged 0010 / 0100 / 0010; kill mask 0010 in the third cycle.
    issue_const(32'h3FC00000, 32'h40000000, 3'd0, 3'd0, 4'b0010, 32'h40400000, 5'h00, 1'b0); advance();
    issue_const(32'h40000000, 32'h40000000, 3'd0, 3'd0, 4'b0100, 32'h40800000, 5'h00, 1'b0); advance();
    issue_const(32'h3FC00000, 32'h3FC00000, 3'd0, 3'd0, 4'b0010, 32'h40100000, 5'h00, 1'b0);
    Kill_Enable    = 1'b1;
    Kill_VKillMask = 4'b0010;
    advance();
    repeat (4) advance();

    // Flush mid-stream, with kill asserted alongside on a non-matching tag.
    for (int i = 0; i < 3; i++) begin
      issue_rand(4'b0001);
      advance();
    end
    issue_rand(4'b0001);
    Flush          = 1'b1;
    Kill_Enable    = 1'b1;
    Kill_VKillMask = 4'b1000;
    advance();
    repeat (5) advance();

    // Asynchronous reset while results and wakeups are in flight.
    for (int i = 0; i < 4; i++) begin
      issue_rand(4'($urandom));
      advance();
    end
    #2 rst = 1'b0;
    #1;
    check("async_rst_res_valid", 64'(bus.res_valid), 64'd0);
    check("async_rst_wake_valid", 64'(bus.wake_valid), 64'd0);
    #1 rst = 1'b1;
    for (int k = step; k < SB_DEPTH; k++) sb[k] = '0;
    @(negedge clk);
    step++;
    repeat (6) advance();

    // Randomized stream with occasional kills and flushes.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 9) < 8) issue_rand(4'($urandom));
      if ($urandom_range(0, 9) == 0) begin
        Kill_Enable    = 1'b1;
        Kill_VKillMask = 4'b0001 << $urandom_range(0, 3);
      end
      if ($urandom_range(0, 49) == 0) Flush = 1'b1;
      advance();
    end
    repeat (5) advance();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/fp_mul_fu.md
Name: fp_mul_fu

Overview:
Single-precision (IEEE-754 binary32) floating-point multiply functional unit for the out-of-order core's execution units. It accepts one issued FMUL.S per cycle from the scheduler port and delivers a rounded result with RISC-V fflags 3 cycles later. It raises a tag wakeup one cycle before the result and drops in-flight ops on Flush or on a mispredict kill that matches their speculation tag.

Parameters:
SPEC_STATES, 4, width of the speculation-tag mask carried per instruction.
ROB_W, 6, ROB index width.
PRF_W, 7, physical destination register tag width.

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous, active-low reset
Flush  in  1  pipeline flush, synchronous
Kill_Enable  in  1  branch mispredict kill strobe
Kill_VKillMask  in  SPEC_STATES  speculation tags being killed
fcsr_frm  in  3  dynamic rounding mode from fcsr
Port_Valid  in  1  issue strobe
in_op1, in_op2  in  32  binary32 operands
in_rm  in  3  instruction rounding mode (7 = dynamic)
in_rob  in  ROB_W  ROB index
in_rd  in  PRF_W  destination tag
in_spectag  in  SPEC_STATES  speculation mask of the op
Ready  out  1  constant 1 (fully pipelined)
wake_valid, wake_rd  out  1, PRF_W  early wakeup
res_valid, res_rob, res_rd  out  1, ROB_W, PRF_W  result tags
res_value  out  32  product
res_fflags  out  5  {NV,DZ,OF,UF,NX}
res_exc  out  1  illegal-instruction (bad rounding mode)

Behaviour:
- Pipeline:
  - 3 stages S1–S3. An op issued with Port_Valid in cycle T gives res_valid in cycle T+3, and wake_valid/wake_rd in cycle T+2.
  - One op per cycle. Each stage holds valid, rob, rd, spectag and its datapath state.
- Reset: while rst=0, all stage valids are cleared. All outputs are 0 except Ready=1.
- Flush: clears every stage valid on the next edge and drops the op being issued that cycle.
- Kill: when Kill_Enable=1, any stage or incoming op with (spectag & Kill_VKillMask) != 0 is invalidated on that edge.
  - A killed op never produces wake_valid or res_valid.
  - Flush and kill in the same cycle: Flush dominates.
- Outputs when a valid is 0: res_*, wake_* and res_exc are driven 0.
- Rounding mode: effective rm = in_rm, or fcsr_frm when in_rm=7.
  - Effective rm of 5, 6 or 7 → res_exc=1, res_value=0, res_fflags=0, delivered with normal latency.
- Datapath:
  - Sign = s1 xor s2. Exponent = e1 + e2 - 127.
  - 24x24 significand product with implicit 1, normalised by 0 or 1 bit.
  - Guard/round/sticky rounding per RNE, RTZ, RDN, RUP, RMM. A mantissa carry on rounding increments the exponent.
- Subnormals (flush-to-zero):
  - Subnormal inputs are treated as signed zero.
  - A result whose post-rounding exponent is below 1 becomes signed zero with UF|NX.
- Special cases, in priority order:
  - Any NaN operand → 0x7FC00000. NV is set only if an operand is a signaling NaN (exp all ones, mantissa≠0, bit22=0).
  - Inf × 0 → 0x7FC00000 with NV.
  - Inf × finite/inf → signed inf, flags 0.
  - Zero × finite → signed zero, flags 0.
- Overflow (biased exponent ≥ 255 after rounding): OF|NX set.
  - RNE/RMM → signed inf.
  - RTZ → signed max finite (0x7F7FFFFF magnitude).
  - RDN → -inf if negative, else +max.
  - RUP → +inf if positive, else -max.
- Inexact: NX is set when any discarded bit is nonzero.
- DZ: always 0.
- Independence: back-to-back ops are independent. A kill of one op does not disturb neighbours with non-matching tags.

Test Plan:
- 0x3FC00000 × 0x40000000, rm=RNE, issued at T → wake_valid at T+2 with wake_rd=in_rd; res_value 0x40400000, fflags 0x00 at T+3.
- 0x3F800001 × 0x3F800001: rm=RNE → 0x3F800002, fflags 0x01; rm=RUP → 0x3F800003, fflags 0x01; rm=7 with fcsr_frm=RTZ → 0x3F800002.
- Specials:
  - 0x7F800000 × 0x00000000 → 0x7FC00000, fflags 0x10.
  - 0x7F800001 × 0x3F800000 → 0x7FC00000, fflags 0x10.
  - 0xFF800000 × 0x40000000 → 0xFF800000, fflags 0.
- Overflow 0x7F000000 × 0x7F000000: RTZ → 0x7F7FFFFF, fflags 0x05; RNE → 0x7F800000, fflags 0x05. Underflow 0x00800000 × 0x3F000000 → 0x00000000, fflags 0x03.
- Kill and flush:
  - Issue ops at T (spectag 0010), T+1 (0100), T+2 (0010). At T+2 assert Kill_Enable with mask 0010 → only the T+1 op produces wakeup/result, at T+4.
  - Flush mid-stream → no further res_valid.
- rm=5 → res_exc=1, res_value 0 at T+3.
- Drop rst low asynchronously mid-stream → res_valid and wake_valid fall immediately; no results after release.
